// File: rtl/hps_spi_pkg.sv
// Shared definitions for the HPS SPI slave register bridge: the state
// encoding, command byte layout and bus widths.
package hps_spi_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int CMD_RW_BIT = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/hps_spi_slave_if.sv
// Single-cycle register bus between the SPI slave (master side of the bus)
// and the fabric register file (slave side).
interface hps_spi_slave_if #(
    parameter int ADDR_W = hps_spi_pkg::ADDR_W,
    parameter int DATA_W = hps_spi_pkg::DATA_W
) ();

    logic [ADDR_W-1:0] REG_ADDR;
    logic [DATA_W-1:0] REG_WDATA;
    logic              REG_WE;
    logic              REG_RE;
    logic [DATA_W-1:0] REG_RDATA;

    modport master (
        output REG_ADDR,
        output REG_WDATA,
        output REG_WE,
        output REG_RE,
        input  REG_RDATA
    );

    modport slave (
        input  REG_ADDR,
        input  REG_WDATA,
        input  REG_WE,
        input  REG_RE,
        output REG_RDATA
    );

endinterface

// File: rtl/spi_pin_sync.sv
// N-flop synchroniser for one SPI pin, followed by one extra stage used for
// edge detection. The level output is that extra stage, so level, rise and
// fall all change on the same CLK edge.
module spi_pin_sync #(
    parameter int   N    = 2,
    parameter logic INIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [N-1:0] stage_in;
    logic [N-1:0] sync_reg;
    logic         prev_reg;
    logic         rise_reg;
    logic         fall_reg;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_in[gi] = din;
            end else begin : g_next
                assign stage_in[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    // Synchroniser chain plus the registered edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {N{INIT}};
            prev_reg <= INIT;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            sync_reg <= stage_in;
            prev_reg <= sync_reg[N-1];
            rise_reg <= sync_reg[N-1] & ~prev_reg;
            fall_reg <= ~sync_reg[N-1] & prev_reg;
        end
    end

    assign level = prev_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/hps_spi_slave.sv
// SPI mode-0 slave that turns a command/address byte plus data bytes into
// single-cycle register bus accesses. Everything runs on CLK; the SPI pins
// are oversampled.
module hps_spi_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = hps_spi_pkg::ADDR_W,
    parameter int DATA_W      = hps_spi_pkg::DATA_W
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            SPIM_CLK,
    input  logic            SPIM_MOSI,
    input  logic            SPIM_SS,
    output logic            SPIM_MISO,
    output logic            FRAME_ERR,
    hps_spi_slave_if.master bus
);

    import hps_spi_pkg::*;

    localparam int                CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);

    logic sck_level_unused, sck_rise, sck_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;
    logic ss_level, ss_rise_unused, ss_fall_unused;

    // SS resets to "selected" so that a frame already running at reset
    // release is parked in HOLD instead of being decoded from the middle.
    spi_pin_sync #(.N(SYNC_STAGES), .INIT(1'b0)) u_sck_sync (
        .clk(CLK), .rst_n(RESET_N), .din(SPIM_CLK),
        .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_pin_sync #(.N(SYNC_STAGES), .INIT(1'b0)) u_mosi_sync (
        .clk(CLK), .rst_n(RESET_N), .din(SPIM_MOSI),
        .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_pin_sync #(.N(SYNC_STAGES), .INIT(1'b0)) u_ss_sync (
        .clk(CLK), .rst_n(RESET_N), .din(SPIM_SS),
        .level(ss_level), .rise(ss_rise_unused), .fall(ss_fall_unused)
    );

    state_t              state_reg;
    logic                armed_reg;
    logic [CNT_W-1:0]    bit_cnt_reg;
    logic [DATA_W-2:0]   shift_in_reg;
    logic                rw_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic                we_reg;
    logic                re_reg;
    logic                re_d_reg;
    logic                frame_err_reg;
    logic [DATA_W-1:0]   miso_shift_reg;
    logic                miso_reg;

    logic [DATA_W-1:0]   byte_in;
    logic [CNT_W-1:0]    cnt_after;
    logic                byte_done;

    // Byte as it stands including the bit sampled on this SCK rise; the
    // counter value after this cycle decides whether SS release is clean.
    assign byte_in   = {shift_in_reg, mosi_level};
    assign cnt_after = sck_rise ? bit_cnt_reg + CNT_W'(1) : bit_cnt_reg;
    assign byte_done = sck_rise && (bit_cnt_reg == LAST);

    // Frame FSM, register bus strobes and MISO shifter.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg      <= IDLE;
            armed_reg      <= 1'b0;
            bit_cnt_reg    <= '0;
            shift_in_reg   <= '0;
            rw_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            we_reg         <= 1'b0;
            re_reg         <= 1'b0;
            re_d_reg       <= 1'b0;
            frame_err_reg  <= 1'b0;
            miso_shift_reg <= '0;
            miso_reg       <= 1'b0;
        end else begin
            we_reg        <= 1'b0;
            re_reg        <= 1'b0;
            frame_err_reg <= 1'b0;
            re_d_reg      <= re_reg;

            // A write is presented at its own address; step afterwards.
            if (we_reg) begin
                addr_reg <= addr_reg + ADDR_W'(1);
            end

            case (state_reg)
                IDLE: begin
                    miso_reg    <= 1'b0;
                    bit_cnt_reg <= '0;
                    if (ss_level) begin
                        armed_reg <= 1'b1;
                    end else if (armed_reg) begin
                        state_reg <= CMD;
                    end else begin
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    miso_reg    <= 1'b0;
                    bit_cnt_reg <= '0;
                    if (ss_level) begin
                        armed_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                CMD: begin
                    miso_reg <= 1'b0;
                    if (sck_rise) begin
                        shift_in_reg <= byte_in[DATA_W-2:0];
                        bit_cnt_reg  <= cnt_after;
                        if (byte_done) begin
                            addr_reg  <= byte_in[ADDR_W-1:0];
                            rw_reg    <= byte_in[CMD_RW_BIT];
                            re_reg    <= byte_in[CMD_RW_BIT];
                            state_reg <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (sck_rise) begin
                        shift_in_reg <= byte_in[DATA_W-2:0];
                        bit_cnt_reg  <= cnt_after;
                        if (byte_done) begin
                            if (rw_reg) begin
                                addr_reg <= addr_reg + ADDR_W'(1);
                                re_reg   <= 1'b1;
                            end else begin
                                wdata_reg <= byte_in;
                                we_reg    <= 1'b1;
                            end
                        end
                    end
                    if (sck_fall) begin
                        if (rw_reg) begin
                            miso_reg       <= miso_shift_reg[DATA_W-1];
                            miso_shift_reg <= {miso_shift_reg[DATA_W-2:0], 1'b0};
                        end else begin
                            miso_reg <= 1'b0;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Read data arrives one CLK after the strobe and is loaded ahead
            // of the next SCK fall.
            if (re_d_reg) begin
                miso_shift_reg <= bus.REG_RDATA;
            end

            // SS release ends the frame; a partially shifted byte is dropped.
            if ((state_reg == CMD || state_reg == DATA) && ss_level) begin
                state_reg   <= IDLE;
                miso_reg    <= 1'b0;
                bit_cnt_reg <= '0;
                if (cnt_after != '0) begin
                    frame_err_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.REG_ADDR  = addr_reg;
    assign bus.REG_WDATA = wdata_reg;
    assign bus.REG_WE    = we_reg;
    assign bus.REG_RE    = re_reg;
    assign SPIM_MISO     = miso_reg;
    assign FRAME_ERR     = frame_err_reg;

endmodule
